sha256core_out_collect: RTL and testbench

Receiving end of the sha256core result stream. Accepts the core's 16-bit `dout`/`dout_en` output, one word per enabled cycle, and assembles each 16-word (256-bit) SHA-256 result into one of two ping-pong slots. It presents completed results to the downstream consumer as 8 x 32-bit words through a valid/read handshake. It sits between sha256core and the result packet builder.

---
 rtl/sha256core_out_collect_pkg.sv | 9 +
 rtl/sha256_result_slot.sv | 24 ++
 rtl/sha256core_out_collect.sv | 98 +++++++++
 tb/tb_sha256core_out_collect.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sha256core_out_collect_pkg.sv
// Shared sizing constants for the sha256core result path.
package sha256core_out_collect_pkg;

    localparam int CORE_DOUT_WIDTH   = 16;
    localparam int RESULT_CORE_WORDS = 16;
    localparam int RESULT_OUT_WORDS  = 8;
    localparam int NUM_SLOTS         = 2;

endpackage

// File: rtl/sha256_result_slot.sv
// One result slot: write-indexed register file, read as adjacent word pairs.
module sha256_result_slot #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       CLK,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH/2)-1:0] raddr,
    output logic [2*DATA_W-1:0]        rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Storage is never reset; full bits in the parent gate its visibility.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Earlier core word lands in the low half.
    assign rdata = {mem[{raddr, 1'b1}], mem[{raddr, 1'b0}]};

endmodule

// File: rtl/sha256core_out_collect.sv
// Collects 16-bit core output words into two ping-pong result slots and
// presents each completed result as eight 32-bit words.
module sha256core_out_collect
    import sha256core_out_collect_pkg::*;
#(
    parameter int IN_WIDTH  = CORE_DOUT_WIDTH,
    parameter int OUT_WIDTH = 2 * CORE_DOUT_WIDTH,
    parameter int IN_WORDS  = RESULT_CORE_WORDS
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_en,
    output logic                 ready_in,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 rd_en,
    output logic                 dout_last,
    output logic                 err_overflow
);

    localparam int WA        = $clog2(IN_WORDS);
    localparam int OUT_WORDS = IN_WORDS / 2;
    localparam int RA        = $clog2(OUT_WORDS);

    if (OUT_WIDTH != 2 * IN_WIDTH) begin : g_bad_width
        $error("OUT_WIDTH must be twice IN_WIDTH");
    end

    logic [NUM_SLOTS-1:0]                full;
    logic                                wr_slot;
    logic [WA-1:0]                       wr_cnt;
    logic                                rd_slot;
    logic [RA-1:0]                       rd_idx;

    logic                                wr_fire, wr_done, rd_fire, rd_done, ovf;
    logic [NUM_SLOTS-1:0]                full_set, full_clr, slot_we;
    logic [NUM_SLOTS-1:0][OUT_WIDTH-1:0] slot_rdata;

    // All decisions use pre-edge full bits, so a slot freed on this edge
    // still rejects a write arriving on the same edge.
    assign wr_fire = din_en && !full[wr_slot];
    assign wr_done = wr_fire && (wr_cnt == WA'(IN_WORDS - 1));
    assign ovf     = din_en && full[wr_slot];
    assign rd_fire = rd_en && full[rd_slot];
    assign rd_done = rd_fire && (rd_idx == RA'(OUT_WORDS - 1));

    assign full_set = wr_done ? (NUM_SLOTS'(1) << wr_slot) : '0;
    assign full_clr = rd_done ? (NUM_SLOTS'(1) << rd_slot) : '0;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign slot_we[g] = wr_fire && (wr_slot == 1'(g));

        sha256_result_slot #(
            .DATA_W (IN_WIDTH),
            .DEPTH  (IN_WORDS)
        ) u_slot (
            .CLK   (CLK),
            .we    (slot_we[g]),
            .waddr (wr_cnt),
            .wdata (din),
            .raddr (rd_idx),
            .rdata (slot_rdata[g])
        );
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            full         <= '0;
            wr_slot      <= 1'b0;
            wr_cnt       <= '0;
            rd_slot      <= 1'b0;
            rd_idx       <= '0;
            err_overflow <= 1'b0;
        end else begin
            // Set and clear never target the same slot: one needs it empty, the other full.
            full <= (full | full_set) & ~full_clr;

            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) wr_slot <= ~wr_slot;
            end

            if (rd_fire) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_done) rd_slot <= ~rd_slot;
            end

            if (ovf) err_overflow <= 1'b1;
        end
    end

    assign ready_in   = !full[wr_slot];
    assign dout_valid = full[rd_slot];
    assign dout       = slot_rdata[rd_slot];
    assign dout_last  = dout_valid && (rd_idx == RA'(OUT_WORDS - 1));

endmodule

// File: tb/tb_sha256core_out_collect.sv
// Directed self-checking bench for sha256core_out_collect.
module tb_sha256core_out_collect;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        din_en;
    logic        ready_in;
    logic [31:0] dout;
    logic        dout_valid;
    logic        rd_en;
    logic        dout_last;
    logic        err_overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sha256core_out_collect dut (
        .CLK          (CLK),
        .reset        (reset),
        .din          (din),
        .din_en       (din_en),
        .ready_in     (ready_in),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .rd_en        (rd_en),
        .dout_last    (dout_last),
        .err_overflow (err_overflow)
    );

    // One enabled core word; returns 1ns after the capturing edge.
    task automatic wr(input logic [15:0] d);
        @(negedge CLK);
        din    = d;
        din_en = 1'b1;
        @(posedge CLK);
        #1 din_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Reads 8 words with rd_en held high, checking each against base+k pairs.
    task automatic drain(input logic [15:0] base, input string nm);
        logic [15:0] lo, hi;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            lo  = base + 16'(2 * i);
            hi  = lo + 16'd1;
            exp = {hi, lo};
            if (dout_valid !== 1'b1) begin
                n_err++; $display("FAIL %s valid[%0d] got=%b want=1", nm, i, dout_valid);
            end
            n_cmp++;
            if (dout !== exp) begin
                n_err++; $display("FAIL %s dout[%0d] got=%h want=%h", nm, i, dout, exp);
            end
            n_cmp++;
            if (dout_last !== (i == 7)) begin
                n_err++; $display("FAIL %s last[%0d] got=%b want=%b", nm, i, dout_last, (i == 7));
            end
            n_cmp++;
            rd_en = 1'b1;
            @(posedge CLK);
            #1 rd_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = '0; din_en = 1'b0; rd_en = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK) reset = 1'b0;
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL reset ready_in got=%b want=1", ready_in); end
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset dout_valid got=%b want=0", dout_valid); end
        n_cmp++;
        if (dout_last !== 1'b0) begin n_err++; $display("FAIL reset dout_last got=%b want=0", dout_last); end
        n_cmp++;
        if (err_overflow !== 1'b0) begin n_err++; $display("FAIL reset err_overflow got=%b want=0", err_overflow); end
        n_cmp++;
    endtask

    task automatic test_single();
        for (int k = 0; k < 15; k++) wr(16'(k));
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single early_valid got=%b want=0", dout_valid); end
        n_cmp++;
        wr(16'h000F);
        drain(16'h0000, "single");
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single valid_drop got=%b want=0", dout_valid); end
        n_cmp++;
    endtask

    task automatic test_gapped();
        for (int k = 0; k < 15; k++) begin
            wr(16'(k));
            idle_cycle();
        end
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL gapped early_valid got=%b want=0", dout_valid); end
        n_cmp++;
        wr(16'h000F);
        drain(16'h0000, "gapped");
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL gapped valid_drop got=%b want=0", dout_valid); end
        n_cmp++;
    endtask

    task automatic test_pingpong_overflow();
        for (int k = 0; k < 16; k++) wr(16'h1000 + 16'(k));
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL pingpong ready_mid got=%b want=1", ready_in); end
        n_cmp++;
        for (int k = 0; k < 16; k++) wr(16'h2000 + 16'(k));
        if (ready_in !== 1'b0) begin n_err++; $display("FAIL pingpong ready_in got=%b want=0", ready_in); end
        n_cmp++;
        if (err_overflow !== 1'b0) begin n_err++; $display("FAIL pingpong err_overflow got=%b want=0", err_overflow); end
        n_cmp++;
        wr(16'hDEAD);
        if (err_overflow !== 1'b1) begin n_err++; $display("FAIL overflow flag got=%b want=1", err_overflow); end
        n_cmp++;
        drain(16'h1000, "pp_slot0");
        drain(16'h2000, "pp_slot1");
        if (err_overflow !== 1'b1) begin n_err++; $display("FAIL overflow sticky got=%b want=1", err_overflow); end
        n_cmp++;
        if (ready_in !== 1'b1 || dout_valid !== 1'b0) begin
            n_err++; $display("FAIL pingpong empty ready=%b valid=%b want ready=1 valid=0", ready_in, dout_valid);
        end
        n_cmp++;
    endtask

    // Slot 1's word 15 lands on the same edge that reads slot 0's word 7.
    task automatic test_simultaneous();
        logic [31:0] exp;
        for (int k = 0; k < 16; k++) wr(16'h3000 + 16'(k));
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            din    = 16'h4000 + 16'(k);
            din_en = 1'b1;
            rd_en  = (k >= 8);
            if (k >= 8) begin
                exp = {16'h3000 + 16'(2 * (k - 8) + 1), 16'h3000 + 16'(2 * (k - 8))};
                if (dout !== exp) begin n_err++; $display("FAIL simul rd[%0d] got=%h want=%h", k - 8, dout, exp); end
                n_cmp++;
            end
            @(posedge CLK);
            #1 din_en = 1'b0;
            rd_en = 1'b0;
        end
        if (dout_valid !== 1'b1) begin n_err++; $display("FAIL simul valid got=%b want=1", dout_valid); end
        n_cmp++;
        if (dout !== 32'h4001_4000) begin n_err++; $display("FAIL simul word0 got=%h want=40014000", dout); end
        n_cmp++;
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL simul ready_in got=%b want=1", ready_in); end
        n_cmp++;
        drain(16'h4000, "simul_slot1");
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 16; k++) wr(16'h5000 + 16'(k));
        for (int k = 0; k < 7; k++) wr(16'h5100 + 16'(k));
        reset = 1'b1;
        @(negedge CLK) reset = 1'b0;
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL rstmid ready_in got=%b want=1", ready_in); end
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid dout_valid got=%b want=0", dout_valid); end
        n_cmp++;
        if (err_overflow !== 1'b0) begin n_err++; $display("FAIL rstmid err_overflow got=%b want=0", err_overflow); end
        n_cmp++;
        for (int k = 0; k < 16; k++) wr(16'h6000 + 16'(k));
        drain(16'h6000, "rstmid");
        if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid valid_drop got=%b want=0", dout_valid); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_gapped();
        test_pingpong_overflow();
        test_simultaneous();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
